// File: rtl/ad9643_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ad9643_pkg
// Purpose  : Shared types and constants for the AD9643 SPI register controller.
// Revision : 1.0
// ============================================================================
package ad9643_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = 16;
    localparam int FRAME_W = 24;

    localparam logic [ADDR_W-1:0] CHIP_CFG = 13'h000;
    localparam logic [ADDR_W-1:0] CHIP_ID  = 13'h001;
    localparam logic [ADDR_W-1:0] TRANSFER = 13'h0FF;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {rw, 2'b00, addr, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad9643_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : ad9643_sclk_gen
// Purpose  : Half-period counter producing sclk plus rise/fall/half-end strobes.
// Revision : 1.0
// ============================================================================
module ad9643_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_toggle_en,
    output logic o_half_end,
    output logic o_rise,
    output logic o_fall,
    output logic o_sclk
);

    localparam int                 c_CNT_W    = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sclk;
    logic               w_last;

    assign w_last     = i_en && (r_cnt == c_CNT_LAST);
    assign o_half_end = w_last;
    assign o_rise     = w_last && i_toggle_en && !r_sclk;
    assign o_fall     = w_last && i_toggle_en && r_sclk;
    assign o_sclk     = r_sclk;

    // With toggling suppressed the counter still paces SETUP/HOLD at sclk low.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last && i_toggle_en) begin
                r_sclk <= !r_sclk;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ad9643_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ad9643_spi_ctrl
// Purpose  : 3-wire SPI master for AD9643 register access (24-bit frames).
//            Define AD9643_SPI_READBACK_EN to enable register reads.
// Revision : 1.0
// ============================================================================
module ad9643_spi_ctrl
    import ad9643_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CSB_IDLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sclk,
    output logic              csb,
    output logic              sdio_o,
    output logic              sdio_oe,
    input  logic              sdio_i
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("CLK_DIV must be at least 2");
    end
    if (CSB_IDLE < 1) begin : g_bad_csb_idle
        $error("CSB_IDLE must be at least 1");
    end

    localparam int                  c_GAP_W       = (CSB_IDLE > 1) ? $clog2(CSB_IDLE) : 1;
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST    = c_GAP_W'(CSB_IDLE - 1);
    localparam logic [4:0]          c_LAST_BIT    = 5'(FRAME_W - 1);
    localparam logic [4:0]          c_LAST_INSTR  = 5'(INSTR_W - 1);

    state_t               r_state;
    logic                 r_ready;
    logic                 r_csb;
    logic                 r_sdio_o;
    logic                 r_sdio_oe;
    logic                 r_rsp_valid;
    logic [FRAME_W-2:0]   r_tx;
    logic [4:0]           r_bit;
    logic [c_GAP_W-1:0]   r_gap;
    logic                 w_rw;
    logic [FRAME_W-1:0]   w_frame;
    logic                 w_gen_en;
    logic                 w_toggle_en;
    logic                 w_half_end;
    logic                 w_fall;
    logic                 w_unused_rise;

`ifdef AD9643_SPI_READBACK_EN
    logic                 r_read;
    logic [DATA_W-1:0]    r_rx;
    logic [DATA_W-1:0]    r_rdata;
    assign w_rw      = cmd_rw;
    assign rsp_rdata = r_rdata;
`else
    logic                 w_unused_in;
    assign w_rw        = 1'b0;
    assign rsp_rdata   = '0;
    assign w_unused_in = sdio_i ^ cmd_rw;
`endif

    assign w_frame     = build_frame(w_rw, cmd_addr, cmd_wdata);
    assign w_gen_en    = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
    assign w_toggle_en = (r_state == ST_SHIFT);

    ad9643_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_gen_en),
        .i_toggle_en (w_toggle_en),
        .o_half_end  (w_half_end),
        .o_rise      (w_unused_rise),
        .o_fall      (w_fall),
        .o_sclk      (sclk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_csb       <= 1'b1;
            r_sdio_o    <= 1'b0;
            r_sdio_oe   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_tx        <= '0;
            r_bit       <= '0;
            r_gap       <= '0;
`ifdef AD9643_SPI_READBACK_EN
            r_read      <= 1'b0;
            r_rx        <= '0;
            r_rdata     <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (cmd_valid && r_ready) begin
                        r_state   <= ST_SETUP;
                        r_ready   <= 1'b0;
                        r_csb     <= 1'b0;
                        r_sdio_oe <= 1'b1;
                        r_sdio_o  <= w_frame[FRAME_W-1];
                        r_tx      <= w_frame[FRAME_W-2:0];
                        r_bit     <= '0;
`ifdef AD9643_SPI_READBACK_EN
                        r_read    <= cmd_rw;
                        r_rx      <= '0;
`endif
                    end
                end
                ST_SETUP: begin
                    if (w_half_end) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The falling strobe closes a bit: next data bit and read capture share it.
                    if (w_fall) begin
                        r_sdio_o <= r_tx[FRAME_W-2];
                        r_tx     <= {r_tx[FRAME_W-3:0], 1'b0};
                        r_bit    <= r_bit + 1'b1;
`ifdef AD9643_SPI_READBACK_EN
                        if (r_read && (r_bit == c_LAST_INSTR)) begin
                            r_sdio_oe <= 1'b0;
                        end
                        if (r_read && (r_bit > c_LAST_INSTR)) begin
                            r_rx <= {r_rx[DATA_W-2:0], sdio_i};
                        end
`endif
                        if (r_bit == c_LAST_BIT) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_half_end) begin
                        r_state     <= ST_GAP;
                        r_csb       <= 1'b1;
                        r_sdio_oe   <= 1'b0;
                        r_sdio_o    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_gap       <= '0;
`ifdef AD9643_SPI_READBACK_EN
                        r_rdata     <= r_read ? r_rx : '0;
`endif
                    end
                end
                ST_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = (r_state != ST_IDLE);
    assign csb       = r_csb;
    assign sdio_o    = r_sdio_o;
    assign sdio_oe   = r_sdio_oe;
    assign rsp_valid = r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_ad9643_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad9643_spi_ctrl
// Purpose  : Directed self-checking bench for ad9643_spi_ctrl with an ADC model.
// Revision : 1.0
// ============================================================================
module tb_ad9643_spi_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int CSB_IDLE  = 2;
    localparam int FRAME_LOW = 50 * CLK_DIV;
    localparam int SPACING   = 1 + FRAME_LOW + CSB_IDLE;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_rw    = 1'b0;
    logic [12:0] cmd_addr  = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        sdio_i    = 1'b0;
    logic        cmd_ready, rsp_valid, busy, sclk, csb, sdio_o, sdio_oe;
    logic [7:0]  rsp_rdata;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] adc_byte = 8'h00;

    // Frame monitor state, sampled on the falling clock edge.
    logic        p_csb = 1'b1, p_sclk = 1'b0, p_sdo = 1'b0;
    int          m_cyc = 0, m_low = 0, m_rises = 0, m_drop = -1, m_sdo_bad = 0;
    logic [23:0] m_bits = '0;
    logic        m_oe_all = 1'b1;
    int          m_nfall = 0, m_last_fall = 0, m_prev_fall = 0;
    int          m_ndone = 0, m_rsp = 0;
    logic [23:0] d_bits = '0;
    int          d_low = 0, d_rises = 0, d_drop = -1, d_sdo_bad = 0;
    logic        d_oe_all = 1'b0;
    logic        m_rsp_edge_ok = 1'b0;

    ad9643_spi_ctrl #(.CLK_DIV(CLK_DIV), .CSB_IDLE(CSB_IDLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sclk      (sclk),
        .csb       (csb),
        .sdio_o    (sdio_o),
        .sdio_oe   (sdio_oe),
        .sdio_i    (sdio_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        m_cyc++;
        if (p_csb && !csb) begin
            m_low = 0; m_rises = 0; m_drop = -1; m_sdo_bad = 0;
            m_bits = '0; m_oe_all = 1'b1; sdio_i = 1'b0;
            m_nfall++; m_prev_fall = m_last_fall; m_last_fall = m_cyc;
        end
        if (!p_csb && csb) begin
            d_bits = m_bits; d_low = m_low; d_rises = m_rises;
            d_drop = m_drop; d_sdo_bad = m_sdo_bad; d_oe_all = m_oe_all;
            m_ndone++;
        end
        if (!csb) begin
            m_low++;
            if (!sdio_oe) m_oe_all = 1'b0;
            if (p_sclk && sclk && (sdio_o != p_sdo)) m_sdo_bad++;
            if (!p_sclk && sclk) begin
                m_bits = {m_bits[22:0], sdio_o};
                if (!sdio_oe && m_drop < 0) m_drop = m_rises;
                if (m_rises >= 16 && m_rises < 24) sdio_i = adc_byte[23 - m_rises];
                m_rises++;
            end
        end
        if (rsp_valid) begin
            m_rsp++;
            m_rsp_edge_ok = !p_csb && csb;
        end
        p_csb = csb; p_sclk = sclk; p_sdo = sdio_o;
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic send(input logic rw, input logic [12:0] a, input logic [7:0] d);
        int n = 0;
        while (!cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
        chk_eq("ready_timeout", {31'b0, cmd_ready}, 32'd1);
        cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int prev);
        int n = 0;
        while (m_rsp == prev && n < 1000) begin @(posedge clk); #1; n++; end
        chk_eq("rsp_timeout", m_rsp, prev + 1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (m_ndone < target && n < 1000) begin @(posedge clk); #1; n++; end
        chk_eq("done_timeout", m_ndone, target);
    endtask

    task automatic chk_frame(input string tag, input logic [23:0] exp_bits,
                             input logic [23:0] mask, input int exp_drop);
        chk_eq({tag, "_bits"}, {8'h0, d_bits & mask}, {8'h0, exp_bits & mask});
        chk_eq({tag, "_csb_low"}, d_low, FRAME_LOW);
        chk_eq({tag, "_nbits"}, d_rises, 24);
        chk_eq({tag, "_oe_drop"}, d_drop, exp_drop);
        chk_eq({tag, "_oe_all"}, {31'b0, d_oe_all}, {31'b0, exp_drop < 0});
        chk_eq({tag, "_sdo_stable"}, d_sdo_bad, 0);
        chk_eq({tag, "_rsp_edge"}, {31'b0, m_rsp_edge_ok}, 32'd1);
        chk_eq({tag, "_sclk_idle"}, {31'b0, sclk}, 32'd0);
    endtask

    initial begin
        int r0, f0, d0, n;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_csb", {31'b0, csb}, 32'd1);
        chk_eq("rst_sclk", {31'b0, sclk}, 32'd0);
        chk_eq("rst_sdio_o", {31'b0, sdio_o}, 32'd0);
        chk_eq("rst_sdio_oe", {31'b0, sdio_oe}, 32'd0);
        chk_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk_eq("rst_rdata", {24'b0, rsp_rdata}, 32'h0);
        chk_eq("rst_busy", {31'b0, busy}, 32'd0);
        chk_eq("rst_ready", {31'b0, cmd_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_eq("ready_after_rst", {31'b0, cmd_ready}, 32'd1);

        // Write 0x01 to TRANSFER (0x0FF)
        r0 = m_rsp;
        send(1'b0, 13'h0FF, 8'h01);
        chk_eq("wr1_csb_after_accept", {31'b0, csb}, 32'd0);
        chk_eq("wr1_busy", {31'b0, busy}, 32'd1);
        chk_eq("wr1_ready_low", {31'b0, cmd_ready}, 32'd0);
        wait_rsp(r0);
        chk_frame("wr1", 24'h00FF01, 24'hFFFFFF, -1);
        chk_eq("wr1_rdata", {24'b0, rsp_rdata}, 32'h0);
        chk_eq("gap_busy", {31'b0, busy}, 32'd1);
        chk_eq("gap_ready", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        chk_eq("idle_ready", {31'b0, cmd_ready}, 32'd1);
        chk_eq("idle_busy", {31'b0, busy}, 32'd0);

`ifdef AD9643_SPI_READBACK_EN
        adc_byte = 8'h82;
        r0 = m_rsp;
        send(1'b1, 13'h001, 8'h00);
        wait_rsp(r0);
        chk_frame("rd", 24'h800100, 24'hFFFF00, 16);
        chk_eq("rd_rdata", {24'b0, rsp_rdata}, 32'h82);
        repeat (5) @(posedge clk);
        #1;
        chk_eq("rd_rdata_hold", {24'b0, rsp_rdata}, 32'h82);
`else
        adc_byte = 8'h82;
        r0 = m_rsp;
        send(1'b1, 13'h001, 8'h3C);
        wait_rsp(r0);
        chk_frame("rd_as_wr", 24'h00013C, 24'hFFFFFF, -1);
        chk_eq("rd_as_wr_rdata", {24'b0, rsp_rdata}, 32'h0);
`endif

        r0 = m_rsp;
        send(1'b0, 13'h1555, 8'hA5);
        wait_rsp(r0);
        chk_frame("wr2", 24'h1555A5, 24'hFFFFFF, -1);
        chk_eq("wr2_rdata", {24'b0, rsp_rdata}, 32'h0);

        // Back-to-back: cmd_valid held high, fields changed after the first accept
        n = 0;
        while (!cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
        r0 = m_rsp; f0 = m_nfall; d0 = m_ndone;
        cmd_rw = 1'b0; cmd_addr = 13'h000; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_addr = 13'h0FF; cmd_wdata = 8'hC3;
        wait_done(d0 + 1);
        chk_frame("b2b_a", 24'h00005A, 24'hFFFFFF, -1);
        n = 0;
        while (m_nfall < f0 + 2 && n < 1000) begin @(posedge clk); #1; n++; end
        cmd_valid = 1'b0;
        chk_eq("b2b_spacing", m_last_fall - m_prev_fall, SPACING);
        wait_done(d0 + 2);
        chk_frame("b2b_b", 24'h00FFC3, 24'hFFFFFF, -1);
        repeat (4) @(posedge clk);
        #1;
        chk_eq("b2b_rsp_count", m_rsp - r0, 2);

        // Reset during bit 10
        r0 = m_rsp;
        send(1'b0, 13'h0FF, 8'h01);
        @(posedge clk); #1;
        n = 0;
        while (m_rises < 10 && n < 1000) begin @(posedge clk); #1; n++; end
        chk_eq("abort_reach_bit10", m_rises, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_eq("abort_csb", {31'b0, csb}, 32'd1);
        chk_eq("abort_sclk", {31'b0, sclk}, 32'd0);
        chk_eq("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_eq("abort_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk_eq("abort_no_rsp", m_rsp, r0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
